axi_slv_rd: RTL
===============

AXI_SLV_RD -- requirements
Module: axi_slv_rd

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, AR request queue depth (power of two, >=2).
REQ-002 The block SHALL have parameter RD_LAT, default 2, wait cycles between request pop and rvalid (0..15).
REQ-003 The block SHALL have parameter MEM_WORDS, default 16, count of legal addresses (0..MEM_WORDS-1).
REQ-004 The block SHALL have parameter DATA_BASE, default 32'hA5A5_0000, constant added to read data.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset: clk input 1 system clock; rst_n input 1 asynchronous active-low reset.
REQ-006 The block SHALL have port axi_slv_arid input `AXI_ID_WIDTH, read request ID.
REQ-007 The block SHALL have port axi_slv_araddr input `AXI_ADDR_WIDTH, read word address.
REQ-008 The block SHALL have port axi_slv_arvalid input 1, request valid; axi_slv_arready output 1, request accept.
REQ-009 The block SHALL have port axi_slv_rid output `AXI_ID_WIDTH, response ID, equal to the accepted arid.
REQ-010 The block SHALL have port axi_slv_rdata output `AXI_DATA_WIDTH, read data.
REQ-011 The block SHALL have port axi_slv_rresp output 2, response code (2'b00 OKAY, 2'b11 DECERR).
REQ-012 The block SHALL have port axi_slv_rlast output 1, last beat; axi_slv_rvalid output 1; axi_slv_rready input 1.

Function
REQ-013 The block SHALL accept an AR request on any rising edge where arvalid and arready are both 1, and push {arid, araddr} into the FIFO.
REQ-014 arready SHALL be registered and equal 1 exactly when FIFO occupancy < FIFO_DEPTH; a pop in the same cycle SHALL NOT enable a push when the FIFO is full.
REQ-015 The FIFO SHALL preserve order; read and write pointers SHALL wrap modulo FIFO_DEPTH, with occupancy tracked in a log2(FIFO_DEPTH)+1 bit counter.
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-017 IDLE with the FIFO non-empty SHALL pop the head into the response registers, load the wait counter with RD_LAT, and go to WAIT, or go directly to RESP if RD_LAT=0.
REQ-018 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter reaches 0; WAIT SHALL last exactly RD_LAT cycles.
REQ-019 RESP SHALL drive rvalid=1 with rid/rdata/rresp/rlast stable until the rvalid&rready edge, then return to IDLE; there SHALL be one idle bubble between responses.
REQ-020 For an idle, empty block, rvalid SHALL rise RD_LAT+1 edges after the AR handshake edge.
REQ-021 rdata SHALL be DATA_BASE + zero-extended araddr, modulo 2^`AXI_DATA_WIDTH; rlast SHALL be 1 on every response (single-beat reads only).
REQ-022 rresp SHALL be 2'b00 unless changed by REQ-027.
REQ-023 Simultaneous AR push and FSM pop SHALL both take effect, leaving occupancy unchanged.
REQ-024 rready asserted while rvalid=0 SHALL be ignored; rvalid SHALL NOT drop without a handshake.

Reset
REQ-025 On rst_n low, asynchronously: FIFO flushed (pointers and count 0); FSM in IDLE; counter 0; arready 0; rvalid 0; rid, rdata and rresp 0; rlast 0.
REQ-026 arready SHALL rise on the first edge after reset release; an in-flight response at reset SHALL be discarded without a handshake.

Configuration
REQ-027 With AXI_SLV_DECERR_EN defined, a request with araddr >= MEM_WORDS SHALL return rresp=2'b11 and rdata=0; without the macro, all addresses SHALL return rresp=2'b00 with rdata per REQ-021.

Verification
REQ-028 Single read (RD_LAT=2): arid=3, araddr=5, rready=1 -> rvalid high 3 edges after handshake, rid=3, rdata=32'hA5A5_0005, rresp=0, rlast=1.
REQ-029 Back-pressure: 5 back-to-back requests with rready=0 -> arready=0 after the 4th accept plus the 1st pop (FIFO full), no push lost; releasing rready returns all 5 in order of ID.
REQ-030 RD_LAT=0: one request -> rvalid high on the 1st edge after the handshake.
REQ-031 With AXI_SLV_DECERR_EN, araddr=16 -> rresp=2'b11 and rdata=0; without it -> rresp=0 and rdata=32'hA5A5_0010.
REQ-032 Reset asserted during WAIT with 2 entries queued -> rvalid=0 and arready=0 immediately; after release, no stale response and arready=1 on the next edge.
REQ-033 rvalid=1, rready held 0 for 10 cycles -> rid, rdata and rresp stable throughout; the handshake on cycle 11 returns the FSM to IDLE.

Source files
------------

// File: rtl/axi_slv_rd.sv
// Single-beat AXI read slave: AR request FIFO feeding an IDLE/WAIT/RESP response FSM.
// Optional macro AXI_SLV_DECERR_EN returns DECERR with zero data for addresses >= MEM_WORDS.

`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module axi_slv_rd #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned MEM_WORDS  = 16,
    parameter logic [31:0] DATA_BASE  = 32'hA5A5_0000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [`AXI_ID_WIDTH-1:0]     axi_slv_arid,
    input  logic [`AXI_ADDR_WIDTH-1:0]   axi_slv_araddr,
    input  logic                         axi_slv_arvalid,
    output logic                         axi_slv_arready,
    output logic [`AXI_ID_WIDTH-1:0]     axi_slv_rid,
    output logic [`AXI_DATA_WIDTH-1:0]   axi_slv_rdata,
    output logic [1:0]                   axi_slv_rresp,
    output logic                         axi_slv_rlast,
    output logic                         axi_slv_rvalid,
    input  logic                         axi_slv_rready
);

    localparam int unsigned IW  = `AXI_ID_WIDTH;
    localparam int unsigned AW  = `AXI_ADDR_WIDTH;
    localparam int unsigned DW  = `AXI_DATA_WIDTH;
    localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned LW  = 4;
    localparam int unsigned AW1 = AW + 1;

    // Elaboration-time parameter sanity checks
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("axi_slv_rd: FIFO_DEPTH must be a power of two >= 2");
    end
    if (RD_LAT > 15) begin : g_bad_lat
        $error("axi_slv_rd: RD_LAT must be 0..15");
    end
    if (MEM_WORDS < 1) begin : g_bad_mem
        $error("axi_slv_rd: MEM_WORDS must be >= 1");
    end

    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
    } ar_req_t;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e          state_q, state_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    ar_req_t         fifo_q [FIFO_DEPTH];
    ar_req_t         fifo_d [FIFO_DEPTH];
    logic            arready_q, arready_d;
    logic            rvalid_q, rvalid_d;
    logic [IW-1:0]   rid_q, rid_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [1:0]      rresp_q, rresp_d;
    logic            rlast_q, rlast_d;
    logic            push_c, pop_c;
    ar_req_t         head_c;

    assign push_c = axi_slv_arvalid & arready_q;
    assign pop_c  = (state_q == IDLE) && (count_q != '0);
    assign head_c = fifo_q[rd_ptr_q];

`ifdef AXI_SLV_DECERR_EN
    logic head_decerr_c;
    assign head_decerr_c = {1'b0, head_c.addr} >= AW1'(MEM_WORDS);
`endif

    // Request FIFO bookkeeping; arready tracks post-edge occupancy
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_c) begin
            fifo_d[wr_ptr_q] = '{id: axi_slv_arid, addr: axi_slv_araddr};
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d   = count_q + CW'(push_c) - CW'(pop_c);
        arready_d = count_d < CW'(FIFO_DEPTH);
    end

    // Response FSM: pop, wait RD_LAT cycles, hold response until handshake
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        rid_d   = rid_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        rlast_d = rlast_q;
        case (state_q)
            IDLE: begin
                if (pop_c) begin
                    rid_d   = head_c.id;
                    rlast_d = 1'b1;
                    lat_d   = LW'(RD_LAT);
                    state_d = (RD_LAT == 0) ? RESP : WAIT;
`ifdef AXI_SLV_DECERR_EN
                    if (head_decerr_c) begin
                        rdata_d = '0;
                        rresp_d = 2'b11;
                    end else begin
                        rdata_d = DW'(DATA_BASE) + DW'(head_c.addr);
                        rresp_d = 2'b00;
                    end
`else
                    rdata_d = DW'(DATA_BASE) + DW'(head_c.addr);
                    rresp_d = 2'b00;
`endif
                end
            end
            WAIT: begin
                lat_d = lat_q - LW'(1);
                if (lat_q == LW'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (axi_slv_rready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rvalid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lat_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            fifo_q    <= '{default: '0};
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            fifo_q    <= fifo_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    assign axi_slv_arready = arready_q;
    assign axi_slv_rvalid  = rvalid_q;
    assign axi_slv_rid     = rid_q;
    assign axi_slv_rdata   = rdata_q;
    assign axi_slv_rresp   = rresp_q;
    assign axi_slv_rlast   = rlast_q;

endmodule
